// File: rtl/threshold_write_arbiter_pkg.sv
// Shared constants and per-requester frame state
// for the threshold write arbiter.
package threshold_write_arbiter_pkg;

  localparam int NUM_REQ      = 4;
  localparam int ADDR_W       = 17;
  localparam int FRAME_PIXELS = 76800;
  localparam int TOP_ADDR     = FRAME_PIXELS - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/threshold_write_arbiter_if.sv
// Requester handshake and shared BRAM write port
// bundled for the arbiter.
interface threshold_write_arbiter_if #(
  parameter int PIXEL_W = 8
);
  import threshold_write_arbiter_pkg::*;

  logic [NUM_REQ-1:0]              enable_in;
  logic [NUM_REQ-1:0]              req_valid_in;
  logic [NUM_REQ-1:0]              req_sof_in;
  logic [NUM_REQ-1:0][PIXEL_W-1:0] req_pixel_in;
  logic [NUM_REQ-1:0]              req_ready_out;
  logic                            bram_we_out;
  logic [1:0]                      bram_bank_out;
  logic [ADDR_W-1:0]               bram_addr_out;
  logic [PIXEL_W-1:0]              bram_din_out;
  logic [NUM_REQ-1:0]              frame_done_out;
  logic [NUM_REQ-1:0]              err_out;

  modport master (
    output enable_in,
    output req_valid_in,
    output req_sof_in,
    output req_pixel_in,
    input  req_ready_out,
    input  bram_we_out,
    input  bram_bank_out,
    input  bram_addr_out,
    input  bram_din_out,
    input  frame_done_out,
    input  err_out
  );

  modport slave (
    input  enable_in,
    input  req_valid_in,
    input  req_sof_in,
    input  req_pixel_in,
    output req_ready_out,
    output bram_we_out,
    output bram_bank_out,
    output bram_addr_out,
    output bram_din_out,
    output frame_done_out,
    output err_out
  );

endinterface

// File: rtl/threshold_write_arbiter_rr.sv
// Four-way round-robin arbiter with registered
// priority pointer and one-hot grant.
module rr_arbiter_4 (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [3:0] i_req,
  output logic [3:0] o_grant
);

  logic [1:0] r_ptr;
  logic [3:0] w_grant;
  logic [1:0] w_idx;
  logic [1:0] w_cand;

  // Walk backwards so the candidate nearest
  // the pointer is the last one to win.
  always_comb begin
    w_grant = '0;
    w_idx   = r_ptr;
    w_cand  = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (i_req[w_cand]) begin
        w_grant = 4'b0001 << w_cand;
        w_idx   = w_cand;
      end
    end
  end

  assign o_grant = rst_in ? 4'b0000 : w_grant;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ptr <= '0;
    end else if (|w_grant) begin
      r_ptr <= w_idx + 2'd1;
    end
  end

endmodule

// File: rtl/threshold_write_arbiter.sv
// Arbitrates four pixel streams onto one BRAM
// write port, each filling its frame top-down.
module threshold_write_arbiter #(
  parameter int PIXEL_W      = 8,
  parameter int FRAME_PIXELS =
    threshold_write_arbiter_pkg::FRAME_PIXELS
) (
  input logic                      clk_in,
  input logic                      rst_in,
  threshold_write_arbiter_if.slave bus
);
  import threshold_write_arbiter_pkg::*;

  localparam logic [ADDR_W-1:0] TOP =
    ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] TOP_M1 =
    ADDR_W'(FRAME_PIXELS - 2);

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_grant;
  logic [1:0]         w_idx;

  state_t            r_state [NUM_REQ];
  logic [ADDR_W-1:0] r_cnt   [NUM_REQ];
  logic               r_we;
  logic [1:0]         r_bank;
  logic [ADDR_W-1:0]  r_addr;
  logic [PIXEL_W-1:0] r_din;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] r_err;

  assign w_req = bus.req_valid_in & bus.enable_in;

  rr_arbiter_4 u_rr (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  always_comb begin
    w_idx = 2'd0;
    unique case (1'b1)
      w_grant[1]: w_idx = 2'd1;
      w_grant[2]: w_idx = 2'd2;
      w_grant[3]: w_idx = 2'd3;
      default:    w_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_we   <= 1'b0;
      r_bank <= '0;
      r_addr <= '0;
      r_din  <= '0;
      r_done <= '0;
      r_err  <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        r_state[k] <= ST_IDLE;
        r_cnt[k]   <= '0;
      end
    end else begin
      r_we   <= 1'b0;
      r_done <= '0;
      if (|w_grant) begin
        if (bus.req_sof_in[w_idx]) begin
          // A restart while active truncates the
          // old frame but still writes the new one.
          if (r_state[w_idx] == ST_ACTIVE)
            r_err[w_idx] <= 1'b1;
          r_we           <= 1'b1;
          r_bank         <= w_idx;
          r_addr         <= TOP;
          r_din          <= bus.req_pixel_in[w_idx];
          r_state[w_idx] <= ST_ACTIVE;
          r_cnt[w_idx]   <= TOP_M1;
        end else if (r_state[w_idx] == ST_ACTIVE) begin
          r_we   <= 1'b1;
          r_bank <= w_idx;
          r_addr <= r_cnt[w_idx];
          r_din  <= bus.req_pixel_in[w_idx];
          if (r_cnt[w_idx] == '0) begin
            r_state[w_idx] <= ST_DONE;
            r_done[w_idx]  <= 1'b1;
          end else begin
            r_cnt[w_idx] <= r_cnt[w_idx] - 1'b1;
          end
        end else begin
          r_err[w_idx] <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready_out  = w_grant;
  assign bus.bram_we_out    = r_we;
  assign bus.bram_bank_out  = r_bank;
  assign bus.bram_addr_out  = r_addr;
  assign bus.bram_din_out   = r_din;
  assign bus.frame_done_out = r_done;
  assign bus.err_out        = r_err;

endmodule

// File: tb/tb_threshold_write_arbiter.sv
// Directed vectors and corner sequences for
// threshold_write_arbiter.
module tb_threshold_write_arbiter;
  import threshold_write_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  threshold_write_arbiter_if #(.PIXEL_W(8)) bus ();

  threshold_write_arbiter #(
    .PIXEL_W(8),
    .FRAME_PIXELS(76800)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  en, valid, sof;
    logic [31:0] pix;
    logic [3:0]  rdy;
    logic        we;
    logic [1:0]  bank;
    logic [16:0] addr;
    logic [7:0]  din;
    logic [3:0]  fd, err;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(
    logic r, logic [3:0] en, logic [3:0] v,
    logic [3:0] s, logic [31:0] p,
    logic [3:0] rdy, logic we, logic [1:0] b,
    int a, logic [7:0] d,
    logic [3:0] fd, logic [3:0] err);
    vec_t x;
    x.rst = r; x.en = en; x.valid = v;
    x.sof = s; x.pix = p; x.rdy = rdy;
    x.we = we; x.bank = b; x.addr = 17'(a);
    x.din = d; x.fd = fd; x.err = err;
    return x;
  endfunction

  task automatic chk(string n,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    bus.req_valid_in = '0;
    bus.req_sof_in   = '0;
    tick;
    rst = 1'b0;
  endtask

  int cnt [4];
  logic [3:0] started;
  int bad, bad2, nfd;
  int e;

  initial begin
    bus.enable_in    = '0;
    bus.req_valid_in = '0;
    bus.req_sof_in   = '0;
    bus.req_pixel_in = '0;
    tick;
    tick;

    vt[0]  = mk(1, 4'hF, 4'hF, 4'hF, 32'h0,
                4'h0, 0, 0, 0, 8'h00, 4'h0, 4'h0);
    vt[1]  = mk(0, 4'hF, 4'h1, 4'h1, 32'h44332211,
                4'h1, 1, 0, 76799, 8'h11, 4'h0, 4'h0);
    vt[2]  = mk(0, 4'hF, 4'h5, 4'h4, 32'h44332211,
                4'h4, 1, 2, 76799, 8'h33, 4'h0, 4'h0);
    vt[3]  = mk(0, 4'hF, 4'h5, 4'h0, 32'h44332211,
                4'h1, 1, 0, 76798, 8'h11, 4'h0, 4'h0);
    vt[4]  = mk(0, 4'hF, 4'h6, 4'h0, 32'h44332211,
                4'h2, 0, 0, 0, 8'h00, 4'h0, 4'h2);
    vt[5]  = mk(0, 4'hB, 4'h4, 4'h0, 32'h88776655,
                4'h0, 0, 0, 0, 8'h00, 4'h0, 4'h2);
    vt[6]  = mk(0, 4'hF, 4'hC, 4'h8, 32'h88776655,
                4'h4, 1, 2, 76798, 8'h77, 4'h0, 4'h2);
    vt[7]  = mk(0, 4'hF, 4'h8, 4'h8, 32'h88776655,
                4'h8, 1, 3, 76799, 8'h88, 4'h0, 4'h2);
    vt[8]  = mk(0, 4'hF, 4'h1, 4'h1, 32'h88776655,
                4'h1, 1, 0, 76799, 8'h55, 4'h0, 4'h3);
    vt[9]  = mk(0, 4'hF, 4'h0, 4'h0, 32'h88776655,
                4'h0, 0, 0, 0, 8'h00, 4'h0, 4'h3);
    vt[10] = mk(1, 4'hF, 4'hF, 4'h0, 32'h88776655,
                4'h0, 0, 0, 0, 8'h00, 4'h0, 4'h0);
    vt[11] = mk(0, 4'hF, 4'hF, 4'hF, 32'h88776655,
                4'h1, 1, 0, 76799, 8'h55, 4'h0, 4'h0);
    vt[12] = mk(0, 4'hF, 4'h4, 4'h0, 32'h88776655,
                4'h4, 0, 0, 0, 8'h00, 4'h0, 4'h4);
    vt[13] = mk(0, 4'hF, 4'h0, 4'h0, 32'h88776655,
                4'h0, 0, 0, 0, 8'h00, 4'h0, 4'h4);

    for (int i = 0; i < 14; i++) begin
      rst              = vt[i].rst;
      bus.enable_in    = vt[i].en;
      bus.req_valid_in = vt[i].valid;
      bus.req_sof_in   = vt[i].sof;
      bus.req_pixel_in = vt[i].pix;
      #1;
      chk($sformatf("v%0d_ready", i),
          bus.req_ready_out, vt[i].rdy);
      tick;
      chk($sformatf("v%0d_we", i),
          bus.bram_we_out, vt[i].we);
      if (vt[i].we || vt[i].rst) begin
        chk($sformatf("v%0d_bank", i),
            bus.bram_bank_out, vt[i].bank);
        chk($sformatf("v%0d_addr", i),
            bus.bram_addr_out, vt[i].addr);
        chk($sformatf("v%0d_din", i),
            bus.bram_din_out, vt[i].din);
      end
      chk($sformatf("v%0d_fd", i),
          bus.frame_done_out, vt[i].fd);
      chk($sformatf("v%0d_err", i),
          bus.err_out, vt[i].err);
    end

    // all four streaming: strict rotation
    reset_dut;
    bus.enable_in = 4'hF;
    started = '0;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int c = 0; c < 40; c++) begin
      e = c % 4;
      bus.req_valid_in = 4'hF;
      bus.req_sof_in   = ~started;
      for (int k = 0; k < 4; k++)
        bus.req_pixel_in[k] = 8'(c * 4 + k);
      #1;
      chk("rr_ready", bus.req_ready_out,
          4'b0001 << e);
      started[e] = 1'b1;
      tick;
      chk("rr_write",
          {bus.bram_we_out, bus.bram_bank_out,
           bus.bram_addr_out, bus.bram_din_out},
          {1'b1, 2'(e), 17'(76799 - cnt[e]),
           8'(c * 4 + e)});
      cnt[e]++;
    end
    chk("rr_err", bus.err_out, 4'h0);

    // requester 1 restarts after 100 beats
    reset_dut;
    bus.enable_in    = 4'hF;
    bus.req_valid_in = 4'h2;
    for (int b = 0; b < 100; b++) begin
      bus.req_sof_in = (b == 0) ? 4'h2 : 4'h0;
      tick;
    end
    chk("trunc_last_addr", bus.bram_addr_out,
        17'd76700);
    chk("trunc_err_before", bus.err_out, 4'h0);
    bus.req_sof_in = 4'h2;
    tick;
    chk("trunc_err", bus.err_out, 4'h2);
    chk("trunc_restart",
        {bus.bram_we_out, bus.bram_bank_out,
         bus.bram_addr_out},
        {1'b1, 2'd1, 17'd76799});
    bus.req_sof_in = 4'h0;
    tick;
    chk("trunc_next",
        {bus.bram_we_out, bus.bram_bank_out,
         bus.bram_addr_out},
        {1'b1, 2'd1, 17'd76798});
    chk("trunc_err_sticky", bus.err_out, 4'h2);

    // requester 3 paused by enable mid-frame
    reset_dut;
    bus.enable_in    = 4'hF;
    bus.req_valid_in = 4'h8;
    for (int b = 0; b < 11; b++) begin
      bus.req_sof_in = (b == 0) ? 4'h8 : 4'h0;
      tick;
    end
    chk("pause_pre_addr", bus.bram_addr_out,
        17'd76789);
    bus.enable_in = 4'h7;
    bad = 0;
    bad2 = 0;
    for (int b = 0; b < 50; b++) begin
      #1;
      if (bus.req_ready_out[3] !== 1'b0) bad++;
      tick;
      if (bus.bram_we_out !== 1'b0) bad2++;
    end
    chk("pause_ready_low", bad, 0);
    chk("pause_no_write", bad2, 0);
    bus.enable_in = 4'hF;
    tick;
    chk("pause_resume",
        {bus.bram_we_out, bus.bram_bank_out,
         bus.bram_addr_out},
        {1'b1, 2'd3, 17'd76788});
    tick;
    chk("pause_resume2", bus.bram_addr_out,
        17'd76787);
    chk("pause_err", bus.err_out, 4'h0);

    // full frame on requester 0
    reset_dut;
    bus.enable_in    = 4'hF;
    bus.req_valid_in = 4'h1;
    bad = 0;
    nfd = 0;
    for (int b = 0; b < 76800; b++) begin
      bus.req_sof_in      = (b == 0) ? 4'h1 : 4'h0;
      bus.req_pixel_in[0] = 8'(76799 - b);
      tick;
      if (bus.frame_done_out != 4'h0) nfd++;
      if (bus.bram_we_out !== 1'b1 ||
          bus.bram_bank_out !== 2'd0 ||
          bus.bram_addr_out !== 17'(76799 - b) ||
          bus.bram_din_out !== 8'(76799 - b) ||
          bus.err_out !== 4'h0 ||
          bus.frame_done_out !==
            ((b == 76799) ? 4'h1 : 4'h0))
        bad++;
    end
    chk("frame_bad_beats", bad, 0);
    chk("frame_done_count", nfd, 1);
    chk("frame_last",
        {bus.bram_addr_out, bus.frame_done_out},
        {17'd0, 4'h1});
    bus.req_valid_in = 4'h0;
    tick;
    chk("frame_done_pulse", bus.frame_done_out,
        4'h0);
    bus.req_valid_in = 4'h1;
    tick;
    chk("done_no_write", bus.bram_we_out, 1'b0);
    chk("done_err", bus.err_out, 4'h1);
    bus.req_valid_in = 4'h0;
    tick;

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
